// File: rtl/genpad_pkg.sv
// genpad_pkg: shared types and constants for the Genesis/Master System pad poll sequencer.
//   - genpad_type_e   : classified pad type (MS, 3-button, 6-button)
//   - genpad_state_e  : poll sequencer FSM states
//   - BTN_*           : bit positions in the 12-bit decoded button word {Z,Y,X,M,S,C,B,A,U,D,L,R}
//   - PHASE_*         : SELECT phase numbers at which pins are captured
//   - genpad_mask()   : buttons that exist on a given pad type
package genpad_pkg;

  typedef enum logic [1:0] {
    GENPAD_MS = 2'b00,
    GENPAD_3B = 2'b01,
    GENPAD_6B = 2'b10
  } genpad_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StPhase,
    StGap,
    StCommit
  } genpad_state_e;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_A = 4;
  localparam int unsigned BTN_B = 5;
  localparam int unsigned BTN_C = 6;
  localparam int unsigned BTN_S = 7;
  localparam int unsigned BTN_M = 8;
  localparam int unsigned BTN_X = 9;
  localparam int unsigned BTN_Y = 10;
  localparam int unsigned BTN_Z = 11;

  localparam logic [2:0] PHASE_BASE    = 3'd0;  // U,D,L,R,B,C
  localparam logic [2:0] PHASE_GENESIS = 3'd1;  // Genesis detect, A, Start
  localparam logic [2:0] PHASE_SIXBTN  = 3'd5;  // 6-button detect
  localparam logic [2:0] PHASE_EXT     = 3'd6;  // Z,Y,X,Mode
  localparam logic [2:0] PHASE_LAST    = 3'd7;

  // MS pads have no A/Start and no extended buttons; 3-button pads lack Z,Y,X,Mode.
  localparam logic [11:0] MASK_MS = 12'h06F;
  localparam logic [11:0] MASK_3B = 12'h0FF;
  localparam logic [11:0] MASK_6B = 12'hFFF;

  function automatic logic [11:0] genpad_mask(input genpad_type_e pad_type);
    logic [11:0] mask;
    case (pad_type)
      GENPAD_3B: mask = MASK_3B;
      GENPAD_6B: mask = MASK_6B;
      default:   mask = MASK_MS;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/genpad_phase_decoder.sv
// genpad_phase_decoder: per-port shadow capture of pad pins and pad-type classification.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_sample         1 on the last cycle of a SELECT phase for this port
//   i_phase          current SELECT phase number (0..7)
//   i_pins           raw pad pins {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active-low
//   o_type           classified pad type
//   o_decoded        masked active-high buttons {Z,Y,X,M,S,C,B,A,U,D,L,R}
module genpad_phase_decoder
  import genpad_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sample,
  input  logic [2:0]   i_phase,
  input  logic [5:0]   i_pins,
  output genpad_type_e o_type,
  output logic [11:0]  o_decoded
);

  logic [11:0]  r_btn;
  logic         r_genesis;
  logic         r_sixbtn;
  genpad_type_e w_type;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn     <= '0;
      r_genesis <= 1'b0;
      r_sixbtn  <= 1'b0;
    end else if (i_sample) begin
      case (i_phase)
        PHASE_BASE: begin
          r_btn[BTN_U] <= ~i_pins[3];
          r_btn[BTN_D] <= ~i_pins[2];
          r_btn[BTN_L] <= ~i_pins[1];
          r_btn[BTN_R] <= ~i_pins[0];
          r_btn[BTN_B] <= ~i_pins[4];
          r_btn[BTN_C] <= ~i_pins[5];
        end
        PHASE_GENESIS: begin
          // Genesis pads pull Left/Right low while SELECT is low; MS pads cannot.
          r_genesis    <= (i_pins[1:0] == 2'b00);
          r_btn[BTN_A] <= ~i_pins[4];
          r_btn[BTN_S] <= ~i_pins[5];
        end
        PHASE_SIXBTN: begin
          r_sixbtn <= (i_pins[3:0] == 4'b0000);
        end
        PHASE_EXT: begin
          // Extended buttons only appear on this phase for a 6-button pad.
          if (r_sixbtn) begin
            r_btn[BTN_Z] <= ~i_pins[3];
            r_btn[BTN_Y] <= ~i_pins[2];
            r_btn[BTN_X] <= ~i_pins[1];
            r_btn[BTN_M] <= ~i_pins[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_type = GENPAD_MS;
    if (r_genesis) begin
      w_type = r_sixbtn ? GENPAD_6B : GENPAD_3B;
    end
  end

  // Stale extended bits from an earlier 6-button poll are removed by the mask.
  assign o_type    = w_type;
  assign o_decoded = r_btn & genpad_mask(w_type);

endmodule

// File: rtl/genpad_poll_sequencer.sv
// genpad_poll_sequencer: frame-synchronous poll scheduler for up to two Genesis/MS pad ports.
// On an accepted VSync rising edge it runs 8 SELECT phases per port, samples the pins at the
// end of each phase, and commits both ports' type and buttons together with a 1-cycle oVALID.
// Build option: define GENPAD_SECOND_PORT_EN for two-port operation; without it only port 0 is
// polled and the port 1 outputs are tied off (SELECT 1, TYPE 00, DECODED 0).
// Ports:
//   iCLK, iRST_N             clock, asynchronous active-low reset
//   iVSYNC                   asynchronous frame sync, active-high
//   iGENPAD0/1               pad pins, active-low
//   oGENPAD0/1_SELECT        pad SELECT lines
//   oGENPAD0/1_TYPE          00 MS, 01 3-button, 10 6-button
//   oGENPAD0/1_DECODED       active-high buttons {Z,Y,X,M,S,C,B,A,U,D,L,R}
//   oVALID                   1-cycle pulse when new results are committed
//   oBUSY                    high while a poll is in progress
module genpad_poll_sequencer
  import genpad_pkg::*;
#(
  parameter int unsigned SETTLE_CYC     = 50,
  parameter int unsigned PORT_GAP_CYC   = 100,
  parameter int unsigned REPOLL_MIN_CYC = 90000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVSYNC,
  input  logic [5:0]  iGENPAD0,
  input  logic [5:0]  iGENPAD1,
  output logic        oGENPAD0_SELECT,
  output logic        oGENPAD1_SELECT,
  output logic [1:0]  oGENPAD0_TYPE,
  output logic [1:0]  oGENPAD1_TYPE,
  output logic [11:0] oGENPAD0_DECODED,
  output logic [11:0] oGENPAD1_DECODED,
  output logic        oVALID,
  output logic        oBUSY
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > PORT_GAP_CYC) ? SETTLE_CYC : PORT_GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(PORT_GAP_CYC - 1);
  localparam logic [16:0]      REPOLL_MIN  = 17'(REPOLL_MIN_CYC);

  // VSync synchroniser and edge detect
  logic r_vs_meta;
  logic r_vs_sync;
  logic r_vs_prev;
  logic w_vs_rise;

  // Sequencer state
  genpad_state_e    r_state;
  genpad_state_e    w_state_d;
  logic             r_port;
  logic             w_port_d;
  logic [2:0]       r_phase;
  logic [2:0]       w_phase_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [16:0]      r_repoll;

  logic w_phase_end;
  logic w_gap_end;
  logic w_start;
  logic w_sample;
  logic w_commit_load;
  logic w_sel0_d;

  // Port 0 results and SELECT
  logic         r_sel0;
  genpad_type_e r_type0;
  logic [11:0]  r_dec0;
  genpad_type_e w_type0;
  logic [11:0]  w_dec0;

  logic r_valid;
  logic r_busy;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= iVSYNC;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_vs_rise = r_vs_sync & ~r_vs_prev;

  assign w_phase_end = (r_cnt == SETTLE_LAST);
  assign w_gap_end   = (r_cnt == GAP_LAST);
  // Edges that arrive while busy or inside the repoll hold-off are simply dropped.
  assign w_start     = (r_state == StIdle) && w_vs_rise && (r_repoll >= REPOLL_MIN);
  assign w_sample    = (r_state == StPhase) && w_phase_end;

  always_comb begin
    w_state_d = r_state;
    w_port_d  = r_port;
    w_phase_d = r_phase;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StPhase;
          w_port_d  = 1'b0;
          w_phase_d = PHASE_BASE;
          w_cnt_d   = '0;
        end
      end
      StPhase: begin
        if (w_phase_end) begin
          w_cnt_d = '0;
          if (r_phase == PHASE_LAST) begin
`ifdef GENPAD_SECOND_PORT_EN
            w_state_d = (r_port == 1'b0) ? StGap : StCommit;
`else
            w_state_d = StCommit;
`endif
          end else begin
            w_phase_d = r_phase + 3'd1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StGap: begin
        if (w_gap_end) begin
          w_state_d = StPhase;
          w_port_d  = 1'b1;
          w_phase_d = PHASE_BASE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StCommit: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= StIdle;
      r_port  <= 1'b0;
      r_phase <= PHASE_BASE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_port  <= w_port_d;
      r_phase <= w_phase_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Counts idle time since the last commit; a new poll needs a full hold-off.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_repoll <= '0;
    end else if (r_state == StCommit) begin
      r_repoll <= '0;
    end else if ((r_state == StIdle) && (r_repoll < REPOLL_MIN)) begin
      r_repoll <= r_repoll + 17'd1;
    end
  end

  // SELECT is high on even phases, low on odd phases, high whenever the port is not active.
  assign w_sel0_d = ~((w_state_d == StPhase) && (w_port_d == 1'b0) && w_phase_d[0]);

  // Results are loaded on the edge entering COMMIT so they appear with oVALID.
  assign w_commit_load = (r_state != StCommit) && (w_state_d == StCommit);

  genpad_phase_decoder u_dec0 (
    .i_clk     (iCLK),
    .i_rst_n   (iRST_N),
    .i_sample  (w_sample && (r_port == 1'b0)),
    .i_phase   (r_phase),
    .i_pins    (iGENPAD0),
    .o_type    (w_type0),
    .o_decoded (w_dec0)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sel0  <= 1'b1;
      r_type0 <= GENPAD_MS;
      r_dec0  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sel0  <= w_sel0_d;
      r_valid <= (w_state_d == StCommit);
      r_busy  <= (w_state_d != StIdle);
      if (w_commit_load) begin
        r_type0 <= w_type0;
        r_dec0  <= w_dec0;
      end
    end
  end

  assign oGENPAD0_SELECT  = r_sel0;
  assign oGENPAD0_TYPE    = r_type0;
  assign oGENPAD0_DECODED = r_dec0;
  assign oVALID           = r_valid;
  assign oBUSY            = r_busy;

`ifdef GENPAD_SECOND_PORT_EN
  logic         r_sel1;
  genpad_type_e r_type1;
  logic [11:0]  r_dec1;
  genpad_type_e w_type1;
  logic [11:0]  w_dec1;
  logic         w_sel1_d;

  assign w_sel1_d = ~((w_state_d == StPhase) && (w_port_d == 1'b1) && w_phase_d[0]);

  genpad_phase_decoder u_dec1 (
    .i_clk     (iCLK),
    .i_rst_n   (iRST_N),
    .i_sample  (w_sample && (r_port == 1'b1)),
    .i_phase   (r_phase),
    .i_pins    (iGENPAD1),
    .o_type    (w_type1),
    .o_decoded (w_dec1)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sel1  <= 1'b1;
      r_type1 <= GENPAD_MS;
      r_dec1  <= '0;
    end else begin
      r_sel1 <= w_sel1_d;
      if (w_commit_load) begin
        r_type1 <= w_type1;
        r_dec1  <= w_dec1;
      end
    end
  end

  assign oGENPAD1_SELECT  = r_sel1;
  assign oGENPAD1_TYPE    = r_type1;
  assign oGENPAD1_DECODED = r_dec1;
`else
  logic w_unused_pad1;
  assign w_unused_pad1 = ^iGENPAD1;

  assign oGENPAD1_SELECT  = 1'b1;
  assign oGENPAD1_TYPE    = GENPAD_MS;
  assign oGENPAD1_DECODED = '0;
`endif

endmodule

// File: tb/tb_genpad_poll_sequencer.sv
`timescale 1ns/1ps
// Bench for genpad_poll_sequencer with scaled-down timing. Pads are behavioural models
// (MS, 3-button, 6-button with a select-idle timeout); expected results are hand-computed.
module tb_genpad_poll_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned GAP    = 6;
  localparam int unsigned REPOLL = 200;
  localparam int unsigned PAD_TO = 150;
`ifdef GENPAD_SECOND_PORT_EN
  localparam bit          TWO_PORT = 1'b1;
  localparam int unsigned POLL_LEN = 16 * SETTLE + GAP + 1;
`else
  localparam bit          TWO_PORT = 1'b0;
  localparam int unsigned POLL_LEN = 8 * SETTLE + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic [5:0]  pad0;
  logic [5:0]  pad1;
  logic        sel0;
  logic        sel1;
  logic [1:0]  type0;
  logic [1:0]  type1;
  logic [11:0] dec0;
  logic [11:0] dec1;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid = 0;
  int n_sel1_low = 0;

  // Pad model state: kind 0 MS, 1 3-button, 2 6-button; buttons active-high.
  logic [1:0]  kind0 = 2'd0;
  logic [1:0]  kind1 = 2'd0;
  logic [11:0] btn0 = '0;
  logic [11:0] btn1 = '0;
  int          n0 = 0;
  int          n1 = 0;
  int          idle0 = 0;
  int          idle1 = 0;
  logic        selq0 = 1'b1;
  logic        selq1 = 1'b1;

  always #5 clk = ~clk;

  genpad_poll_sequencer #(
    .SETTLE_CYC     (SETTLE),
    .PORT_GAP_CYC   (GAP),
    .REPOLL_MIN_CYC (REPOLL)
  ) dut (
    .iCLK             (clk),
    .iRST_N           (rst_n),
    .iVSYNC           (vsync),
    .iGENPAD0         (pad0),
    .iGENPAD1         (pad1),
    .oGENPAD0_SELECT  (sel0),
    .oGENPAD1_SELECT  (sel1),
    .oGENPAD0_TYPE    (type0),
    .oGENPAD1_TYPE    (type1),
    .oGENPAD0_DECODED (dec0),
    .oGENPAD1_DECODED (dec1),
    .oVALID           (valid),
    .oBUSY            (busy)
  );

  // b: {Z,Y,X,M,S,C,B,A,U,D,L,R}; n: SELECT falling edges since the pad last timed out.
  function automatic logic [5:0] pad_pins(input logic [1:0] kind, input logic [11:0] b,
                                          input logic sel, input int n);
    logic [5:0] p;
    if (kind == 2'd0) begin
      p = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end else if (sel) begin
      if (kind == 2'd2 && n == 3) p = ~{b[6], b[5], b[11], b[10], b[9], b[8]};
      else                        p = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end else begin
      if (kind == 2'd2 && n == 3)      p = {~b[7], ~b[4], 4'b0000};
      else if (kind == 2'd2 && n == 4) p = {~b[7], ~b[4], 4'b1111};
      else                             p = {~b[7], ~b[4], ~b[3], ~b[2], 2'b00};
    end
    return p;
  endfunction

  assign pad0 = pad_pins(kind0, btn0, sel0, n0);
  assign pad1 = pad_pins(kind1, btn1, sel1, n1);

  always @(posedge clk) begin
    selq0 <= sel0;
    selq1 <= sel1;
    idle0 <= (sel0 != selq0) ? 0 : ((idle0 < PAD_TO) ? idle0 + 1 : idle0);
    idle1 <= (sel1 != selq1) ? 0 : ((idle1 < PAD_TO) ? idle1 + 1 : idle1);
    if (selq0 && !sel0)       n0 <= n0 + 1;
    else if (idle0 >= PAD_TO) n0 <= 0;
    if (selq1 && !sel1)       n1 <= n1 + 1;
    else if (idle1 >= PAD_TO) n1 <= 0;
  end

  always @(negedge clk) begin
    if (valid) n_valid <= n_valid + 1;
    if (!sel1) n_sel1_low <= n_sel1_low + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    repeat (2) step();
    vsync = 1'b0;
  endtask

  // Starts a poll and checks its length, the oVALID position and pulse count.
  task automatic run_poll(input string tag, input bit vsync_mid);
    int w = 0;
    int len = 0;
    int vpos = 0;
    int vcnt = 0;
    repeat (REPOLL + 20) step();
    pulse_vsync();
    while (!busy && w < 40) begin
      step();
      w++;
    end
    check_val({tag, "_start"}, 32'(busy), 32'd1);
    while (busy && len < 2000) begin
      if (valid) begin
        vcnt++;
        vpos = len + 1;
      end
      len++;
      if (vsync_mid && len == 10) vsync = 1'b1;
      if (vsync_mid && len == 13) vsync = 1'b0;
      step();
    end
    check_val({tag, "_len"}, 32'(len), 32'(POLL_LEN));
    check_val({tag, "_vpos"}, 32'(vpos), 32'(POLL_LEN));
    check_val({tag, "_vcnt"}, 32'(vcnt), 32'd1);
  endtask

  task automatic check_ports(input string tag, input logic [1:0] t0, input logic [11:0] d0,
                             input logic [1:0] t1, input logic [11:0] d1);
    check_val({tag, "_type0"}, 32'(type0), 32'(t0));
    check_val({tag, "_dec0"}, 32'(dec0), 32'(d0));
    check_val({tag, "_type1"}, 32'(type1), TWO_PORT ? 32'(t1) : 32'd0);
    check_val({tag, "_dec1"}, 32'(dec1), TWO_PORT ? 32'(d1) : 32'd0);
  endtask

  initial begin
    int v0;
    int w;
    // Reset state
    repeat (3) step();
    check_val("rst_sel0", 32'(sel0), 32'd1);
    check_val("rst_sel1", 32'(sel1), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_ports("rst", 2'd0, 12'h000, 2'd0, 12'h000);
    rst_n = 1'b1;

    // VSync inside the post-reset hold-off must be ignored
    repeat (20) step();
    v0 = n_valid;
    pulse_vsync();
    repeat (60) step();
    check_val("early_vcnt", 32'(n_valid - v0), 32'd0);
    check_val("early_busy", 32'(busy), 32'd0);

    // P1: port 0 MS with R+B, port 1 6-button Z+M+C
    kind0 = 2'd0; btn0 = 12'h021;
    kind1 = 2'd2; btn1 = 12'h940;
    run_poll("p1", 1'b0);
    check_ports("p1", 2'd0, 12'h021, 2'd2, 12'h940);

    // P2: port 0 3-button Start+A+Up, VSync edge while busy; port 1 3-button C+B (+Z..M)
    kind0 = 2'd1; btn0 = 12'h098;
    kind1 = 2'd1; btn1 = 12'hF60;
    run_poll("p2", 1'b1);
    check_ports("p2", 2'd1, 12'h098, 2'd1, 12'h060);

    // Edge half-way through the hold-off after a commit: no poll, outputs held
    v0 = n_valid;
    repeat (REPOLL / 2) step();
    pulse_vsync();
    repeat (REPOLL / 2 + 60) step();
    check_val("hold_vcnt", 32'(n_valid - v0), 32'd0);
    check_ports("hold", 2'd1, 12'h098, 2'd1, 12'h060);

    // P3/P4: 6-button Z+M+C on both ports over two consecutive frames
    kind0 = 2'd2; btn0 = 12'h940;
    kind1 = 2'd2; btn1 = 12'h940;
    run_poll("p3", 1'b0);
    check_ports("p3", 2'd2, 12'h940, 2'd2, 12'h940);
    run_poll("p4", 1'b0);
    check_ports("p4", 2'd2, 12'h940, 2'd2, 12'h940);

    // P5: 3-button after a 6-button poll; extended bits must not leak
    kind0 = 2'd1; btn0 = 12'hF60;
    kind1 = 2'd0; btn1 = 12'h021;
    run_poll("p5", 1'b0);
    check_ports("p5", 2'd1, 12'h060, 2'd0, 12'h021);

    // Reset during port 0 phase 3
    kind0 = 2'd0; btn0 = 12'h021;
    kind1 = 2'd1; btn1 = 12'h098;
    repeat (REPOLL + 20) step();
    pulse_vsync();
    w = 0;
    while (!busy && w < 40) begin
      step();
      w++;
    end
    repeat (13) step();
    check_val("mid_sel0_low", 32'(sel0), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sel0", 32'(sel0), 32'd1);
    check_val("mid_rst_sel1", 32'(sel1), 32'd1);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_ports("mid_rst", 2'd0, 12'h000, 2'd0, 12'h000);
    step();
    rst_n = 1'b1;
    v0 = n_valid;
    repeat (20) step();
    pulse_vsync();
    repeat (60) step();
    check_val("mid_early_vcnt", 32'(n_valid - v0), 32'd0);
    check_val("mid_early_busy", 32'(busy), 32'd0);

    // P6: recovery after reset
    run_poll("p6", 1'b0);
    check_ports("p6", 2'd0, 12'h021, 2'd1, 12'h098);

`ifndef GENPAD_SECOND_PORT_EN
    check_val("sel1_never_low", 32'(n_sel1_low), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
